// File: rtl/fetch_if.sv
// Fetch-stage bus: decode-side stall/redirect, IMEM address/data, and the
// valid-qualified instruction handed to decode.
interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_dout,
    output imem_addr, instr, instr_pc, instr_valid, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_dout,
    input  imem_addr, instr, instr_pc, instr_valid, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a 1-cycle synchronous IMEM: PC tracking,
// stall replay, redirect squash and an accepted-instruction counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 10;
  localparam logic [XLEN-1:0] PC_RST = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [AW-1:0]   imem_addr_c;
  logic [XLEN-1:0] redir_base;
  logic            take_redirect;
  logic            accept;

  // Redirect is masked during reset so the address bus shows RESET_PC there.
  assign take_redirect = rst_n & bus.redirect;
  assign redir_base    = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign accept        = resp_valid_q & ~bus.redirect & ~bus.stall;

  // Next-state and IMEM address selection: redirect > stall replay > sequential.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    resp_valid_d  = resp_valid_q;
    fetch_count_d = fetch_count_q;
    imem_addr_c   = pc_q[AW+1:2];

    if (accept) fetch_count_d = fetch_count_q + XLEN'(1);

    if (take_redirect) begin
      imem_addr_c  = bus.redirect_pc[AW+1:2];
      resp_pc_d    = redir_base;
      resp_valid_d = 1'b1;
      pc_d         = redir_base + XLEN'(4);
    end else if (bus.stall && resp_valid_q) begin
      imem_addr_c  = resp_pc_q[AW+1:2];
    end else begin
      imem_addr_c  = pc_q[AW+1:2];
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
      pc_d         = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= PC_RST;
      resp_pc_q     <= '0;
      resp_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      resp_valid_q  <= resp_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = imem_addr_c;
  assign bus.instr       = bus.imem_dout;
  assign bus.instr_pc    = resp_pc_q;
  assign bus.instr_valid = resp_valid_q & ~bus.redirect;
  assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM[i]=i behind a 1-cycle IMEM; accepted instructions
// are checked against a queue of expected (pc, instr) pairs.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  always #5 clk = ~clk;

  fetch_if bus_a ();
  fetch_if bus_b ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a));
  fetch_unit #(.RESET_PC(32'h0000_0FF8)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b));

  // ROM[i] = i, synchronous read
  always_ff @(posedge clk) begin
    bus_a.imem_dout <= 32'(bus_a.imem_addr);
    bus_b.imem_dout <= 32'(bus_b.imem_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];
  int unsigned exp_cnt = 0;

  // Monitor: every accepted instruction on DUT A must match the next queue entry
  always @(negedge clk) begin
    if (!rst_n_a) begin
      exp_cnt = 0;
    end else if (bus_a.instr_valid === 1'b1 && bus_a.stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_accept: got pc 0x%08h expected no acceptance", bus_a.instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr_pc", bus_a.instr_pc, e.pc);
        chk("sb_instr", bus_a.instr, e.instr);
        chk("sb_fetch_count", bus_a.fetch_count, 32'(exp_cnt));
        exp_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.stall = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_pc = '0;
    bus_b.stall = 1'b0; bus_b.redirect = 1'b0; bus_b.redirect_pc = '0;

    push(32'h0, 32'd0);
    push(32'h4, 32'd1);
    push(32'h8, 32'd2);
    push(32'hC, 32'd3);
    push(32'h100, 32'd64);

    repeat (3) step();
    chk("rst_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("rst_count", bus_a.fetch_count, 32'd0);
    chk("rst_addr", 32'(bus_a.imem_addr), 32'd0);

    rst_n_a = 1'b1;
    #1;
    chk("first_bubble_valid", 32'(bus_a.instr_valid), 32'd0);
    step();
    chk("first_pc", bus_a.instr_pc, 32'h0);
    chk("first_valid", 32'(bus_a.instr_valid), 32'd1);
    step();
    step();

    // instr_pc = 0x8 shown; stall three cycles
    bus_a.stall = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_instr", bus_a.instr, 32'd2);
      chk("stall_pc", bus_a.instr_pc, 32'h8);
      chk("stall_valid", 32'(bus_a.instr_valid), 32'd1);
      chk("stall_count", bus_a.fetch_count, 32'd2);
      chk("stall_addr", 32'(bus_a.imem_addr), 32'd2);
      step();
    end
    bus_a.stall = 1'b0;
    step();
    chk("post_stall_pc", bus_a.instr_pc, 32'hC);
    step();
    chk("pre_redirect_pc", bus_a.instr_pc, 32'h10);

    // Redirect squashes 0x10
    bus_a.redirect = 1'b1;
    bus_a.redirect_pc = 32'h103;
    #1;
    chk("redirect_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("redirect_addr", 32'(bus_a.imem_addr), 32'h40);
    step();
    bus_a.redirect = 1'b0;
    #1;
    chk("target_pc", bus_a.instr_pc, 32'h100);
    chk("target_instr", bus_a.instr, 32'd64);
    step();
    chk("target_next_pc", bus_a.instr_pc, 32'h104);

    // Redirect and stall together: redirect wins
    bus_a.stall = 1'b1;
    bus_a.redirect = 1'b1;
    bus_a.redirect_pc = 32'h40;
    #1;
    chk("rs_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("rs_addr", 32'(bus_a.imem_addr), 32'h10);
    step();
    bus_a.redirect = 1'b0;
    #1;
    chk("rs_target_pc", bus_a.instr_pc, 32'h40);
    chk("rs_target_instr", bus_a.instr, 32'd16);
    chk("rs_target_valid", 32'(bus_a.instr_valid), 32'd1);
    chk("rs_count", bus_a.fetch_count, 32'd5);

    // Asynchronous reset while stalled
    #1;
    rst_n_a = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("async_rst_count", bus_a.fetch_count, 32'd0);
    chk("async_rst_addr", 32'(bus_a.imem_addr), 32'd0);
    bus_a.stall = 1'b0;
    step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Wrap across the 1024-word IMEM with RESET_PC = 0xFF8
    chk("wrap_rst_addr", 32'(bus_b.imem_addr), 32'h3FE);
    rst_n_b = 1'b1;
    step();
    chk("wrap_pc0", bus_b.instr_pc, 32'hFF8);
    chk("wrap_instr0", bus_b.instr, 32'h3FE);
    chk("wrap_addr1", 32'(bus_b.imem_addr), 32'h3FF);
    step();
    chk("wrap_pc1", bus_b.instr_pc, 32'hFFC);
    chk("wrap_instr1", bus_b.instr, 32'h3FF);
    chk("wrap_addr2", 32'(bus_b.imem_addr), 32'h000);
    step();
    chk("wrap_pc2", bus_b.instr_pc, 32'h1000);
    chk("wrap_instr2", bus_b.instr, 32'h0);
    chk("wrap_count", bus_b.fetch_count, 32'd2);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the synchronous-read instruction memory (1-cycle read latency, 10-bit word address, 32-bit data). It holds the program counter, drives the IMEM word address, tracks which PC the word currently on the IMEM output belongs to, and presents a valid-qualified instruction to decode. It handles downstream stall by replaying the held address and handles branch/jump redirect by squashing the in-flight word.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] ignored.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept this cycle.
- redirect  in  1  taken branch/jump; overrides stall.
- redirect_pc  in  32  new byte address; bits [1:0] treated as 0.
- imem_addr  out  10  word address to IMEM, combinational.
- imem_dout  in  32  IMEM read data, valid one cycle after address.
- instr  out  32  instruction to decode, equal to imem_dout.
- instr_pc  out  32  byte address of instr.
- instr_valid  out  1  instr/instr_pc meaningful this cycle.
- fetch_count  out  32  number of instructions accepted by decode.

## Operation
- State registers: pc (next byte address to request), resp_pc (address of word on imem_dout), resp_valid, fetch_count.
- Acceptance: instruction consumed on a cycle with instr_valid=1 and stall=0; fetch_count increments by 1 on each acceptance, wraps modulo 2^32.
- instr_valid = resp_valid & ~redirect; instr = imem_dout; instr_pc = resp_pc.
- Per-cycle priority, highest first:
  - redirect=1: imem_addr = redirect_pc[11:2]; next: resp_pc <= {redirect_pc[31:2],2'b00}, resp_valid <= 1, pc <= that + 4. The word currently on imem_dout is squashed and not counted.
  - stall=1 and resp_valid=1: imem_addr = resp_pc[11:2] (replay, so imem_dout stays on the same word); pc, resp_pc, resp_valid hold.
  - otherwise (includes stall=1 with resp_valid=0, pipeline fill): imem_addr = pc[11:2]; next: resp_pc <= pc, resp_valid <= 1, pc <= pc + 4.
- Arithmetic: pc is 32-bit, pc + 4 wraps at 2^32. imem_addr always takes bits [11:2], so fetch wraps the 1024-word IMEM naturally (pc 0xFFC -> 0x1000 gives index 0x3FF -> 0x000). instr_pc reports the full 32-bit pc.
- Reset (asynchronous, any time, including mid-stall or mid-redirect): pc = {RESET_PC[31:2],2'b00}, resp_pc = 0, resp_valid = 0, fetch_count = 0. Hence instr_valid = 0 and imem_addr = RESET_PC[11:2] while rst_n = 0.

## Timing
- Fetch latency: address presented in cycle N gives a valid instruction in cycle N+1.
- Sustained throughput: one instruction per cycle with stall=0.
- First valid instruction: first rising edge after rst_n deasserts launches RESET_PC; instr_valid = 1 from the following cycle.
- Redirect penalty: one bubble. The redirect cycle shows instr_valid = 0; the target instruction is valid the next cycle.
- Stall: instr, instr_pc and instr_valid are stable for every stalled cycle; release continues with the next sequential word with no bubble.
- Simultaneous redirect and stall: redirect wins; stall is ignored that cycle.
- imem_addr is a combinational path from redirect, redirect_pc and stall; the upstream stage must register those signals.

## Test plan
- Reset/sequential: RESET_PC=0, ROM[i]=i, no stall -> instr_valid low for 1 cycle after reset, then instr_pc 0,4,8,… with instr 0,1,2,… one per cycle; fetch_count tracks accepted words.
- Stall: assert stall for 3 cycles while instr_pc=0x8 -> instr=2 and instr_pc=0x8 held, fetch_count frozen; after release, the next cycles show 0xC then 0x10.
- Redirect: redirect with redirect_pc=0x103 while instr_pc=0x10 -> instr_valid=0 that cycle and 0x10 not counted; next cycle instr_pc=0x100, instr=ROM[64]; then 0x104.
- Redirect during stall: stall=1 and redirect=1 together with redirect_pc=0x40 -> redirect taken; next instr_pc=0x40, valid.
- Wrap: RESET_PC=0xFF8 -> imem_addr 0x3FE, 0x3FF, 0x000; instr_pc 0xFF8, 0xFFC, 0x1000.
- Reset mid-operation: drop rst_n while stalled with fetch_count=5 -> instr_valid=0, fetch_count=0 and imem_addr=RESET_PC[11:2] immediately, without waiting for a clock edge.
